// File: rtl/sort_pkg.sv
// sort_pkg: shared types, sizes and FSM encoding for the 5-word streaming sorter.
// Revision: 1.0
`default_nettype none

package sort_pkg;

    localparam int SORT_N = 5;

    typedef logic [31:0] data_t;

    localparam data_t PAD_VALUE = 32'hFFFF_FFFF;

    typedef logic [SORT_N-1:0][31:0] vec_t;
    typedef logic [2:0]              cnt_t;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sort_stream_5_if.sv
// sort_stream_5_if: input and output valid/ready streams of the sorter.
// Revision: 1.0
`default_nettype none

interface sort_stream_5_if;
    import sort_pkg::*;

    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    logic  in_last;
    logic  out_valid;
    logic  out_ready;
    data_t out_data;
    logic  out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

`default_nettype wire

// File: rtl/sort_net_5.sv
// sort_net_5: combinational ascending sort of 5 unsigned words.
// Revision: 1.0
`default_nettype none

module sort_net_5
    import sort_pkg::*;
(
    input  wire vec_t i_data,
    output vec_t      o_data
);

    vec_t  w_v;
    data_t w_tmp;

    // Odd-even transposition: adjacent-only swaps on strict '>' keep equal words in order.
    always_comb begin
        w_v   = i_data;
        w_tmp = '0;
        for (int s = 0; s < SORT_N; s++) begin
            for (int i = s % 2; i < SORT_N - 1; i += 2) begin
                if (w_v[i] > w_v[i+1]) begin
                    w_tmp    = w_v[i];
                    w_v[i]   = w_v[i+1];
                    w_v[i+1] = w_tmp;
                end
            end
        end
    end

    assign o_data = w_v;

endmodule

`default_nettype wire

// File: rtl/sort_stream_5.sv
// sort_stream_5: collects up to 5 words, sorts them, streams them out ascending.
// Option SORT_STREAM_MEDIAN_ONLY_EN: emit only the median word of each group.
// Revision: 1.0
`default_nettype none

module sort_stream_5
    import sort_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst_n,
    sort_stream_5_if.slave s_if,
    output logic           busy
);

`ifdef SORT_STREAM_MEDIAN_ONLY_EN
    localparam bit c_median_only = 1'b1;
`else
    localparam bit c_median_only = 1'b0;
`endif

    state_t r_state;
    state_t w_next;
    cnt_t   r_cnt;
    cnt_t   r_idx;
    cnt_t   r_n;
    vec_t   r_slot;
    vec_t   r_sorted;
    vec_t   w_sorted;

    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_in_fire;
    logic   w_out_fire;
    logic   w_group_end;
    logic   w_is_last;

    sort_net_5 u_net (
        .i_data (r_slot),
        .o_data (w_sorted)
    );

    assign w_group_end = (r_cnt == cnt_t'(SORT_N - 1)) || s_if.in_last;
    assign w_is_last   = c_median_only ? 1'b1 : (r_idx == (r_n - 3'd1));
    assign w_in_fire   = w_in_ready && s_if.in_valid;
    assign w_out_fire  = w_out_valid && s_if.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_FILL: begin
                w_in_ready = 1'b1;
                if (s_if.in_valid && w_group_end) begin
                    w_next = S_SORT;
                end
            end
            S_SORT: begin
                w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_out_valid = 1'b1;
                if (s_if.out_ready && w_is_last) begin
                    w_next = S_FILL;
                end
            end
            default: begin
                w_next = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_n   <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_in_fire) begin
                        if (w_group_end) begin
                            r_cnt <= '0;
                            r_n   <= r_cnt + 3'd1;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                S_SORT: begin
                    r_idx <= c_median_only ? ((r_n - 3'd1) >> 1) : 3'd0;
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        r_idx <= w_is_last ? 3'd0 : (r_idx + 3'd1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
            endcase
        end
    end

    // Storage carries no reset: a discarded group is simply overwritten by the next one.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_slot[r_cnt] <= s_if.in_data;
            if (w_group_end) begin
                for (int i = 0; i < SORT_N; i++) begin
                    if (3'(i) > r_cnt) begin
                        r_slot[i] <= PAD_VALUE;
                    end
                end
            end
        end
        if (r_state == S_SORT) begin
            r_sorted <= w_sorted;
        end
    end

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = w_out_valid;
    assign s_if.out_data  = w_out_valid ? r_sorted[r_idx] : '0;
    assign s_if.out_last  = w_out_valid && w_is_last;
    assign busy           = (r_state != S_FILL) || (r_cnt != 3'd0);

endmodule

`default_nettype wire

// File: tb/tb_sort_stream_5.sv
// tb_sort_stream_5: directed vectors against hand-computed sorted groups.
// Revision: 1.0
`default_nettype none

module tb_sort_stream_5;

    logic clk;
    logic rst_n;
    logic busy;
    int   n_checks;
    int   n_errs;

    sort_stream_5_if u_if ();

    sort_stream_5 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_if  (u_if),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        check_val("in_ready_fill", {31'd0, u_if.in_ready}, 32'd1);
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        u_if.in_last  = last;
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        u_if.in_data  = 32'd0;
    endtask

    task automatic wait_valid();
        for (int t = 0; t < 20 && !u_if.out_valid; t++) @(negedge clk);
        check_val("valid_wait", {31'd0, u_if.out_valid}, 32'd1);
    endtask

    task automatic drain(input logic [31:0] exp [5], input int n);
        u_if.out_ready = 1'b1;
        wait_valid();
        for (int k = 0; k < n; k++) begin
            check_val("out_data", u_if.out_data, exp[k]);
            check_val("out_last", {31'd0, u_if.out_last}, (k == n - 1) ? 32'd1 : 32'd0);
            check_val("in_ready_drain", {31'd0, u_if.in_ready}, 32'd0);
            @(negedge clk);
        end
        check_val("valid_after", {31'd0, u_if.out_valid}, 32'd0);
        check_val("busy_after", {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] exp_v [5];

    initial begin
        n_checks       = 0;
        n_errs         = 0;
        rst_n          = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = 32'd0;
        u_if.in_last   = 1'b0;
        u_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
        check_val("rst_out_data", u_if.out_data, 32'd0);
        check_val("rst_out_last", {31'd0, u_if.out_last}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef SORT_STREAM_MEDIAN_ONLY_EN
        push(32'd9, 1'b0); push(32'd3, 1'b0); push(32'd7, 1'b0);
        push(32'd1, 1'b0); push(32'd5, 1'b0);
        exp_v = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd0};
        drain(exp_v, 1);
        push(32'd8, 1'b0); push(32'd2, 1'b1);
        exp_v = '{32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
        drain(exp_v, 1);
`else
        // Full group, with exact latency: SORT cycle then DRAIN.
        push(32'd9, 1'b0);
        check_val("busy_fill", {31'd0, busy}, 32'd1);
        push(32'd3, 1'b0); push(32'd7, 1'b0); push(32'd1, 1'b0); push(32'd5, 1'b0);
        check_val("lat_sort", {31'd0, u_if.out_valid}, 32'd0);
        check_val("sort_ready", {31'd0, u_if.in_ready}, 32'd0);
        @(negedge clk);
        check_val("lat_drain", {31'd0, u_if.out_valid}, 32'd1);
        exp_v = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9};
        drain(exp_v, 5);

        // Short group.
        push(32'd42, 1'b0); push(32'd17, 1'b1);
        exp_v = '{32'd17, 32'd42, 32'd0, 32'd0, 32'd0};
        drain(exp_v, 2);

        // Backpressure 1,0,0,1 with stray in_valid held during DRAIN.
        push(32'd30, 1'b0); push(32'd10, 1'b0); push(32'd20, 1'b1);
        wait_valid();
        u_if.in_valid  = 1'b1;
        u_if.in_data   = 32'd99;
        u_if.out_ready = 1'b1;
        check_val("bp_d0", u_if.out_data, 32'd10);
        @(negedge clk);
        u_if.out_ready = 1'b0;
        check_val("bp_d1", u_if.out_data, 32'd20);
        @(negedge clk);
        check_val("bp_hold", u_if.out_data, 32'd20);
        check_val("bp_ready", {31'd0, u_if.in_ready}, 32'd0);
        @(negedge clk);
        check_val("bp_hold2", u_if.out_data, 32'd20);
        u_if.out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_d2", u_if.out_data, 32'd30);
        check_val("bp_last", {31'd0, u_if.out_last}, 32'd1);
        u_if.in_valid = 1'b0;
        u_if.in_data  = 32'd0;
        @(negedge clk);
        check_val("bp_done", {31'd0, u_if.out_valid}, 32'd0);

        // Duplicates and extremes; also proves the stray 99 was not captured.
        push(32'd0, 1'b0); push(32'hFFFF_FFFF, 1'b0); push(32'd5, 1'b0);
        push(32'd5, 1'b0); push(32'd0, 1'b1);
        exp_v = '{32'd0, 32'd0, 32'd5, 32'd5, 32'hFFFF_FFFF};
        drain(exp_v, 5);

        // Reset in the middle of DRAIN.
        push(32'd50, 1'b0); push(32'd40, 1'b0); push(32'd30, 1'b0);
        push(32'd20, 1'b0); push(32'd10, 1'b0);
        u_if.out_ready = 1'b1;
        wait_valid();
        check_val("mr_d0", u_if.out_data, 32'd10);
        @(negedge clk);
        check_val("mr_d1", u_if.out_data, 32'd20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mr_valid", {31'd0, u_if.out_valid}, 32'd0);
        check_val("mr_ready", {31'd0, u_if.in_ready}, 32'd1);
        check_val("mr_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(32'd4, 1'b0); push(32'd2, 1'b0); push(32'd6, 1'b0);
        push(32'd8, 1'b0); push(32'd0, 1'b0);
        exp_v = '{32'd0, 32'd2, 32'd4, 32'd6, 32'd8};
        drain(exp_v, 5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sort_stream_5.md
SORT_STREAM_5 -- requirements
Module: sort_stream_5

Interface
REQ-001 Parameters: none; all widths and counts SHALL come from the shared package.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_data is valid this cycle.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  32 (data_t)  unsigned input word.
REQ-007 in_last  input  1  qualifies the accepted word as the final word of a short group (flush).
REQ-008 out_valid  output  1  out_data is valid this cycle.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  32 (data_t)  sorted output word.
REQ-011 out_last  output  1  marks the final output word of a group.
REQ-012 busy  output  1  high in any state other than FILL, or when FILL holds at least one word.

Function
REQ-013 A transfer SHALL occur on a cycle where valid and ready are both high; data SHALL NOT change while valid is high and ready is low.
REQ-014 FSM states SHALL be FILL, SORT and DRAIN only.
REQ-015 FILL: in_ready=1, out_valid=0; each accepted word SHALL be stored at slot cnt; cnt (3 bits) SHALL increment by 1 per accept.
REQ-016 FILL->SORT SHALL occur on the edge accepting the 5th word, or any word with in_last=1; group size n = cnt+1 at that edge (1..5).
REQ-017 Unfilled slots SHALL be loaded with 32'hFFFF_FFFF on the FILL->SORT edge so they sort last.
REQ-018 SORT: in_ready=0, out_valid=0; the 5 slots SHALL pass through the combinational sort network, with ascending results registered on the edge that moves to DRAIN (exactly one cycle in SORT).
REQ-019 DRAIN: in_ready=0, out_valid=1, out_data=sorted[idx]; idx SHALL advance by 1 per output transfer.
REQ-020 out_last SHALL be 1 when idx==n-1; that transfer SHALL return the FSM to FILL with cnt=0 and idx=0.
REQ-021 Latency: first out_valid SHALL be 2 cycles after the edge accepting the group's final word; full throughput SHALL be one group per n+n+1 cycles with out_ready held high.
REQ-022 Comparisons SHALL be unsigned; equal words SHALL keep input order (stable compare-exchange using <=).
REQ-023 in_valid while in_ready=0 SHALL be ignored; no word SHALL be lost or duplicated.
REQ-024 in_last on the 5th word SHALL behave as a normal full group (n=5).

Reset
REQ-025 rst_n low SHALL immediately force state FILL, cnt=0, idx=0, in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, regardless of state.
REQ-026 A partially filled or partially drained group SHALL be discarded on reset; storage contents need not be cleared.
REQ-027 First accept SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-028 Macro SORT_STREAM_MEDIAN_ONLY_EN defined: DRAIN SHALL emit exactly one word, sorted[(n-1)/2], with out_last=1; the group then returns to FILL.
REQ-029 Macro undefined: DRAIN SHALL emit all n words in ascending order per REQ-019/020.

Structure
REQ-030 Package sort_pkg SHALL hold data_t (logic [31:0]), SORT_N=5, PAD_VALUE=32'hFFFF_FFFF and the state enum.
REQ-031 The combinational network SHALL be one sub-module, sort_net_5, with 5 inputs and 5 ascending outputs and no clock.
REQ-032 sort_stream_5 SHALL contain all registers, the FSM and the handshake logic.

Verification
REQ-033 Full group: accept 9,3,7,1,5 back-to-back, out_ready=1 -> out 1,3,5,7,9 starting 2 cycles after accepting 5, out_last with 9.
REQ-034 Short group: 42,17 with in_last on 17 -> out 17,42, out_last on 42, no pad value emitted.
REQ-035 Backpressure: out_ready toggled 1,0,0,1 during DRAIN -> out_data held stable while stalled, in_ready=0 throughout DRAIN.
REQ-036 Duplicates and extremes: 0,FFFF_FFFF,5,5,0 -> 0,0,5,5,FFFF_FFFF.
REQ-037 Reset mid-DRAIN after 2 outputs -> out_valid=0 immediately; next group 4,2,6,8,0 -> 0,2,4,6,8.
REQ-038 With SORT_STREAM_MEDIAN_ONLY_EN: 9,3,7,1,5 -> single word 5 with out_last=1; short group 8,2 with in_last -> single word 2.
